// File: rtl/weather_pkg.sv
// Shared definitions for the weather-link receiver: state encoding, frame layout,
// reset weather values and the frame parity helper.
package weather_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } rx_state_e;

  localparam int SYNC_W = 4;
  localparam int PAYLOAD_W = 17;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1010;

  // Payload layout, MSB first: {thunderstorm, wind[5:0], visibility[1:0], temperature[7:0]}
  localparam int TS_POS  = 16;
  localparam int WIND_HI = 15;
  localparam int WIND_LO = 10;
  localparam int VIS_HI  = 9;
  localparam int VIS_LO  = 8;
  localparam int TEMP_HI = 7;
  localparam int TEMP_LO = 0;

  localparam logic       RST_THUNDER = 1'b0;
  localparam logic [5:0] RST_WIND    = 6'd0;
  localparam logic [1:0] RST_VIS     = 2'd0;
  localparam logic [7:0] RST_TEMP    = 8'd0;

  function automatic logic parity_even_ok(input logic [PAYLOAD_W-1:0] data, input logic par);
    return ~(^data ^ par);
  endfunction

endpackage

// File: rtl/weather_link_timer.sv
// Link supervision counters: intra-frame gap timeout and saturating stale-link counter.
module weather_link_timer #(
  parameter int BIT_TIMEOUT = 16,
  parameter int STALE_LIMIT = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic gap_en,
  input  logic gap_clr,
  input  logic stale_clr,
  output logic timeout,
  output logic stale
);

  localparam int GAP_W   = $clog2(BIT_TIMEOUT + 1);
  localparam int STALE_W = $clog2(STALE_LIMIT + 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(BIT_TIMEOUT - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_LIMIT);

  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic [STALE_W-1:0] stale_cnt_r, stale_cnt_s;
  logic               stale_r;

  // Next-count logic; timeout fires on the edge that completes BIT_TIMEOUT idle cycles.
  always_comb begin
    gap_cnt_s   = gap_cnt_r;
    stale_cnt_s = stale_cnt_r;
    timeout     = 1'b0;
    if (!gap_en || gap_clr) begin
      gap_cnt_s = '0;
    end else if (gap_cnt_r == GAP_LAST) begin
      timeout   = 1'b1;
      gap_cnt_s = '0;
    end else begin
      gap_cnt_s = gap_cnt_r + GAP_W'(1);
    end
    if (stale_clr) begin
      stale_cnt_s = '0;
    end else if (stale_cnt_r < STALE_MAX) begin
      stale_cnt_s = stale_cnt_r + STALE_W'(1);
    end else begin
      stale_cnt_s = stale_cnt_r;
    end
  end

  // Counter registers; the stale flag is registered alongside its count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gap_cnt_r   <= '0;
      stale_cnt_r <= STALE_MAX;
      stale_r     <= 1'b1;
    end else begin
      gap_cnt_r   <= gap_cnt_s;
      stale_cnt_r <= stale_cnt_s;
      stale_r     <= (stale_cnt_s >= STALE_MAX);
    end
  end

  assign stale = stale_r;

endmodule

// File: rtl/weather_frame_rx.sv
// Serial weather-link receiver: sync hunt, 17-bit payload capture, even parity check,
// and held weather outputs that change only on a good frame or reset.
module weather_frame_rx
  import weather_pkg::*;
#(
  parameter int BIT_TIMEOUT = 16,
  parameter int STALE_LIMIT = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_valid,
  input  logic       rx_bit,
  output logic       thunderstorm,
  output logic [5:0] wind,
  output logic [1:0] visibility,
  output logic [7:0] temperature,
  output logic       frame_ok,
  output logic       parity_err,
  output logic       frame_err,
  output logic       link_stale,
  output logic [1:0] rx_state
);

  localparam logic [4:0] LAST_BIT = 5'(PAYLOAD_W - 1);

  rx_state_e            state_r, state_s;
  logic [SYNC_W-1:0]    sync_r, sync_s;
  logic [PAYLOAD_W-1:0] payload_r, payload_s;
  logic [4:0]           bit_cnt_r, bit_cnt_s;
  logic                 frame_ok_r, parity_err_r, frame_err_r;
  logic                 frame_ok_s, parity_err_s, frame_err_s;
  logic                 thunder_r;
  logic [5:0]           wind_r;
  logic [1:0]           vis_r;
  logic [7:0]           temp_r;
  logic                 in_frame_s, timeout_s, stale_s;

  assign in_frame_s = (state_r == PAYLOAD) || (state_r == PARITY);

  weather_link_timer #(
    .BIT_TIMEOUT(BIT_TIMEOUT),
    .STALE_LIMIT(STALE_LIMIT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .gap_en   (in_frame_s),
    .gap_clr  (rx_valid),
    .stale_clr(frame_ok_s),
    .timeout  (timeout_s),
    .stale    (stale_s)
  );

  // Next-state and pulse decode; a timeout can only fire in a cycle without rx_valid.
  always_comb begin
    state_s      = state_r;
    sync_s       = sync_r;
    payload_s    = payload_r;
    bit_cnt_s    = bit_cnt_r;
    frame_ok_s   = 1'b0;
    parity_err_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      HUNT: begin
        if (rx_valid) begin
          sync_s = {sync_r[SYNC_W-2:0], rx_bit};
          if (sync_s == SYNC_PATTERN) begin
            state_s   = PAYLOAD;
            bit_cnt_s = 5'd0;
          end else begin
            state_s = HUNT;
          end
        end else begin
          sync_s = sync_r;
        end
      end
      PAYLOAD: begin
        if (timeout_s) begin
          frame_err_s = 1'b1;
          state_s     = HUNT;
          sync_s      = '0;
        end else if (rx_valid) begin
          payload_s = {payload_r[PAYLOAD_W-2:0], rx_bit};
          if (bit_cnt_r == LAST_BIT) begin
            state_s = PARITY;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      PARITY: begin
        if (timeout_s) begin
          frame_err_s = 1'b1;
          state_s     = HUNT;
          sync_s      = '0;
        end else if (rx_valid) begin
          if (parity_even_ok(payload_r, rx_bit)) begin
            frame_ok_s = 1'b1;
          end else begin
            parity_err_s = 1'b1;
          end
          state_s = HUNT;
          sync_s  = '0;
        end else begin
          state_s = PARITY;
        end
      end
      default: begin
        state_s = HUNT;
        sync_s  = '0;
      end
    endcase
  end

  // State, shifters, pulses and held weather values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= HUNT;
      sync_r       <= '0;
      payload_r    <= '0;
      bit_cnt_r    <= 5'd0;
      frame_ok_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      thunder_r    <= RST_THUNDER;
      wind_r       <= RST_WIND;
      vis_r        <= RST_VIS;
      temp_r       <= RST_TEMP;
    end else begin
      state_r      <= state_s;
      sync_r       <= sync_s;
      payload_r    <= payload_s;
      bit_cnt_r    <= bit_cnt_s;
      frame_ok_r   <= frame_ok_s;
      parity_err_r <= parity_err_s;
      frame_err_r  <= frame_err_s;
      if (frame_ok_s) begin
        thunder_r <= payload_r[TS_POS];
        wind_r    <= payload_r[WIND_HI:WIND_LO];
        vis_r     <= payload_r[VIS_HI:VIS_LO];
        temp_r    <= payload_r[TEMP_HI:TEMP_LO];
      end
    end
  end

  assign thunderstorm = thunder_r;
  assign wind         = wind_r;
  assign visibility   = vis_r;
  assign temperature  = temp_r;
  assign frame_ok     = frame_ok_r;
  assign parity_err   = parity_err_r;
  assign frame_err    = frame_err_r;
  assign link_stale   = stale_s;
  assign rx_state     = state_r;

endmodule

// File: tb/tb_weather_frame_rx.sv
// Directed bench for weather_frame_rx: good/bad frames, timeout, overlapping sync,
// stale-link threshold and mid-frame reset, against hand-computed values.
module tb_weather_frame_rx;

  logic       CLK;
  logic       RST;
  logic       rx_valid;
  logic       rx_bit;
  logic       thunderstorm;
  logic [5:0] wind;
  logic [1:0] visibility;
  logic [7:0] temperature;
  logic       frame_ok;
  logic       parity_err;
  logic       frame_err;
  logic       link_stale;
  logic [1:0] rx_state;

  int total = 0;
  int bad   = 0;

  weather_frame_rx #(
    .BIT_TIMEOUT(16),
    .STALE_LIMIT(20)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .rx_valid    (rx_valid),
    .rx_bit      (rx_bit),
    .thunderstorm(thunderstorm),
    .wind        (wind),
    .visibility  (visibility),
    .temperature (temperature),
    .frame_ok    (frame_ok),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .link_stale  (link_stale),
    .rx_state    (rx_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_valid = 1'b1;
    rx_bit   = b;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [16:0] pl, input logic par);
    send_bits(32'hA, 4);
    send_bits({15'd0, pl}, 17);
    send_bit(par);
  endtask

  task automatic check_wx(input string tag, input logic ts, input logic [5:0] w,
                          input logic [1:0] v, input logic [7:0] t);
    check_val({tag, "_ts"}, {31'd0, thunderstorm}, {31'd0, ts});
    check_val({tag, "_wind"}, {26'd0, wind}, {26'd0, w});
    check_val({tag, "_vis"}, {30'd0, visibility}, {30'd0, v});
    check_val({tag, "_temp"}, {24'd0, temperature}, {24'd0, t});
  endtask

  task automatic check_pulses(input string tag, input logic ok, input logic pe, input logic fe);
    check_val({tag, "_pulses"}, {29'd0, frame_ok, parity_err, frame_err}, {29'd0, ok, pe, fe});
  endtask

  initial begin
    RST      = 1'b1;
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    idle(3);
    check_wx("reset", 1'b0, 6'd0, 2'd0, 8'd0);
    check_pulses("reset", 1'b0, 1'b0, 1'b0);
    check_val("reset_stale", {31'd0, link_stale}, 32'd1);
    check_val("reset_state", {30'd0, rx_state}, 32'd0);
    RST = 1'b0;
    idle(2);

    // Good frame: wind 12, visibility 1, +20 C
    send_frame(17'b0_001100_01_00010100, 1'b1);
    check_pulses("f1", 1'b1, 1'b0, 1'b0);
    check_wx("f1", 1'b0, 6'd12, 2'd1, 8'd20);
    check_val("f1_stale", {31'd0, link_stale}, 32'd0);
    check_val("f1_state", {30'd0, rx_state}, 32'd0);
    idle(1);
    check_pulses("f1_after", 1'b0, 1'b0, 1'b0);

    // Storm frame: -41 C
    send_frame(17'b1_010101_11_11010111, 1'b0);
    check_pulses("f2", 1'b1, 1'b0, 1'b0);
    check_wx("f2", 1'b1, 6'd21, 2'd3, 8'hD7);

    // Parity failure holds the storm values
    send_frame(17'b0_001100_01_00010100, 1'b0);
    check_pulses("perr", 1'b0, 1'b1, 1'b0);
    check_wx("perr", 1'b1, 6'd21, 2'd3, 8'hD7);
    check_val("perr_state", {30'd0, rx_state}, 32'd0);
    idle(1);
    check_pulses("perr_after", 1'b0, 1'b0, 1'b0);

    // Timeout after 10 payload bits
    send_bits(32'hA, 4);
    send_bits(32'h3FF, 10);
    idle(15);
    check_pulses("to_15", 1'b0, 1'b0, 1'b0);
    check_val("to_15_state", {30'd0, rx_state}, 32'd1);
    idle(1);
    check_pulses("to_16", 1'b0, 1'b0, 1'b1);
    check_val("to_16_state", {30'd0, rx_state}, 32'd0);
    check_wx("to_16", 1'b1, 6'd21, 2'd3, 8'hD7);
    idle(1);
    check_pulses("to_after", 1'b0, 1'b0, 1'b0);
    send_frame(17'b0_001100_01_00010100, 1'b1);
    check_pulses("to_good", 1'b1, 1'b0, 1'b0);
    check_wx("to_good", 1'b0, 6'd12, 2'd1, 8'd20);

    // Overlapping sync: 1,1,0,1,0 syncs on the fifth bit
    send_bits(32'hD, 4);
    check_val("ovl_4th", {30'd0, rx_state}, 32'd0);
    send_bit(1'b0);
    check_val("ovl_5th", {30'd0, rx_state}, 32'd1);
    send_bits({15'd0, 17'b0_111111_10_10000000}, 17);
    check_val("ovl_par_state", {30'd0, rx_state}, 32'd2);
    send_bit(1'b0);
    check_pulses("ovl", 1'b1, 1'b0, 1'b0);
    check_wx("ovl", 1'b0, 6'd63, 2'd2, 8'h80);

    // Stale threshold at 20 cycles after the good frame
    idle(19);
    check_val("stale_19", {31'd0, link_stale}, 32'd0);
    idle(1);
    check_val("stale_20", {31'd0, link_stale}, 32'd1);

    // Asynchronous reset in the middle of a payload
    send_bits(32'hA, 4);
    send_bits(32'h15, 5);
    check_val("mid_state", {30'd0, rx_state}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check_wx("rst_mid", 1'b0, 6'd0, 2'd0, 8'd0);
    check_val("rst_mid_stale", {31'd0, link_stale}, 32'd1);
    check_val("rst_mid_state", {30'd0, rx_state}, 32'd0);
    #1;
    RST = 1'b0;
    idle(1);
    send_frame(17'b1_010101_11_11010111, 1'b0);
    check_pulses("post_rst", 1'b1, 1'b0, 1'b0);
    check_wx("post_rst", 1'b1, 6'd21, 2'd3, 8'hD7);
    check_val("post_rst_stale", {31'd0, link_stale}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weather_frame_rx.md
Name: weather_frame_rx

Overview:
- Serial weather-link receiver and decoder. It is the producing end of the environmental-control unit's weather inputs.
- Hunts for a sync pattern in a strobed bit stream, shifts in a 17-bit weather payload, and checks even parity.
- On a good frame, updates held thunderstorm/wind/visibility/temperature outputs that feed the environmental-control FSM directly.
- Flags parity errors, intra-frame timeouts and a stale link.

Parameters:
- BIT_TIMEOUT, 16: max consecutive CLK cycles without rx_valid inside a frame before abort.
- STALE_LIMIT, 1000: cycles without a good frame before link_stale asserts.

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous, active-high reset
- rx_valid  input  1  bit strobe; rx_bit is sampled on the CLK edge where rx_valid=1
- rx_bit  input  1  serial data, MSB first
- thunderstorm  output  1  held decoded value
- wind  output  6  held decoded value, unsigned
- visibility  output  2  held decoded value
- temperature  output  8  held decoded value, signed two's complement
- frame_ok  output  1  one-cycle pulse on a good frame
- parity_err  output  1  one-cycle pulse on a parity failure
- frame_err  output  1  one-cycle pulse on a timeout abort
- link_stale  output  1  level; no good frame for STALE_LIMIT cycles
- rx_state  output  2  current FSM state

Behaviour:
- Reset (RST is asynchronous, active-high; clock is CLK):
  - thunderstorm=0, wind=0, visibility=0, temperature=0. This is the benign "clear weather" input set.
  - frame_ok, parity_err and frame_err = 0.
  - link_stale=1; the stale counter is loaded to STALE_LIMIT.
  - rx_state=HUNT; sync shifter, payload shifter, bit counter and gap counter are cleared.
- Frame format, 22 bits: sync 4'b1010, then payload[16:0] = {thunderstorm, wind[5:0], visibility[1:0], temperature[7:0]}, then 1 parity bit. Even parity: XOR of payload and parity bit must equal 0.
- State encoding: HUNT=0, PAYLOAD=1, PARITY=2. Code 3 is illegal and returns to HUNT on the next edge.
- HUNT:
  - On each rx_valid, shift rx_bit into the 4-bit sync shifter.
  - When the shifter value including the current bit equals 1010, go to PAYLOAD with bit count 0.
  - Overlapping detection is required: the stream 1,1,0,1,0 syncs on the 5th bit.
- PAYLOAD:
  - Each rx_valid shifts one bit into the payload shifter.
  - On the 17th bit, go to PARITY.
- PARITY: on rx_valid, evaluate parity over the payload plus rx_bit.
  - Pass: on that same edge, load all four outputs from the payload, pulse frame_ok, clear the stale counter and deassert link_stale. Outputs are visible the cycle after the parity bit is sampled.
  - Fail: pulse parity_err; outputs hold their previous values.
  - In both cases, return to HUNT with the sync shifter cleared.
- Timeout:
  - In PAYLOAD or PARITY, the gap counter increments each cycle with rx_valid=0 and resets on rx_valid=1.
  - When the counter reaches BIT_TIMEOUT, pulse frame_err, go to HUNT, and hold the outputs.
  - The gap counter does not run in HUNT.
- Stale counter:
  - Increments every cycle and saturates at STALE_LIMIT.
  - link_stale = (count >= STALE_LIMIT).
  - A good frame has priority over the increment on the same edge.
- Pulses last exactly one cycle. At most one of frame_ok, parity_err, frame_err is high in any cycle.
- Outputs never change except on reset or a good frame. A partial frame never corrupts held values.
- RST mid-frame discards the partial frame and applies the reset values immediately.

Decomposition:
- Shared package (weather_pkg):
  - state encoding constants HUNT/PAYLOAD/PARITY;
  - SYNC_PATTERN=4'b1010, SYNC_W=4, PAYLOAD_W=17;
  - payload field bit positions;
  - default reset weather values.
- One natural sub-module, weather_link_timer: the gap counter plus the saturating stale counter. It provides timeout and stale flags and takes clear/enable inputs.

Test Plan:
- Reset, then 1010 + payload 0_001100_01_00010100 + parity 1 -> frame_ok pulse; wind=12, visibility=1, temperature=+20, thunderstorm=0; link_stale=0.
- 1010 + payload 1_010101_11_11010111 + parity 0 -> thunderstorm=1, wind=21, visibility=3, temperature=-41 (8'hD7), which drives the downstream unit toward its emergency state; frame_ok pulse.
- Same frame as the first scenario with parity 0 -> parity_err pulse, no frame_ok; outputs unchanged from the previous frame; rx_state back to HUNT.
- Sync then 10 payload bits, then 16 idle cycles (BIT_TIMEOUT=16) -> frame_err pulse on the 16th idle cycle, HUNT. A subsequent full good frame decodes correctly.
- Noise 1,1,0,1,0 followed by 17 payload bits and parity -> overlapping sync found at the 5th bit and the frame decodes. Separately, STALE_LIMIT=20 with no frames after a good one -> link_stale rises at count 20.
- RST asserted mid-PAYLOAD -> all outputs return to reset values asynchronously, link_stale=1, rx_state=HUNT. The next frame decodes normally.
